cam_emul: RTL

CAM_EMUL -- requirements
Module: cam_emul

---
 rtl/cam_emul.sv | 134 +++++++++++++
 1 files changed

// File: rtl/cam_emul.sv
// Camera sensor emulator: pclk = clk/2, vsync/href/RGB565 byte stream, one frame per enable.
// Optional macro CAM_EMUL_BARS_EN selects eight vertical colour bars instead of the {x, y} pattern.
module cam_emul #(
    parameter int CAM_SCREEN_X = 160,
    parameter int CAM_SCREEN_Y = 120,
    parameter int HBLANK       = 16,
    parameter int VSYNC_LINES  = 3,
    parameter int VBP          = 2,
    parameter int VFP          = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       CAM_pclk,
    output logic       CAM_vsync,
    output logic       CAM_href,
    output logic [7:0] CAM_px_data,
    output logic       frame_done
);
    // state  | meaning
    // IDLE   | waiting for en on a pclk falling update
    // VSYNC  | vsync high, VSYNC_LINES line periods
    // VBP    | blank lines before active video
    // ACTIVE | CAM_SCREEN_Y lines with href during the first 2*X bytes
    // VFP    | blank lines after active video; exit pulses frame_done
    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_VFP} state_t;

    localparam int LINE_LEN = 2*CAM_SCREEN_X + HBLANK;
    localparam int BW       = $clog2(LINE_LEN);
    localparam int LW       = 16;

    state_t          state_q, state_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic [LW-1:0]   lcnt_q, lcnt_d;
    logic [LW-1:0]   n_lines;
    logic            pclk_q, vsync_q, href_q, done_q, done_d;
    logic            vsync_d, href_d, eol, last_line;
    logic [7:0]      data_q, data_d;
    logic [BW-1:0]   x_w;
    logic [15:0]     pix_w;

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        lcnt_d  = lcnt_q;
        done_d  = 1'b0;
        eol     = (bcnt_q == BW'(LINE_LEN-1));
        case (state_q)
            S_VSYNC:  n_lines = LW'(VSYNC_LINES);
            S_VBP:    n_lines = LW'(VBP);
            S_ACTIVE: n_lines = LW'(CAM_SCREEN_Y);
            S_VFP:    n_lines = LW'(VFP);
            default:  n_lines = LW'(1);
        endcase
        last_line = (lcnt_q == n_lines - 1'b1);

        // Everything advances only on the edge where pclk falls (pclk_q currently 1).
        if (pclk_q) begin
            if (state_q == S_IDLE) begin
                if (en) state_d = S_VSYNC;
                bcnt_d = '0;
                lcnt_d = '0;
            end else if (eol) begin
                bcnt_d = '0;
                if (last_line) begin
                    lcnt_d = '0;
                    case (state_q)
                        S_VSYNC:  state_d = S_VBP;
                        S_VBP:    state_d = S_ACTIVE;
                        S_ACTIVE: state_d = S_VFP;
                        S_VFP: begin
                            done_d  = 1'b1;
                            state_d = en ? S_VSYNC : S_IDLE;
                        end
                        default:  state_d = S_IDLE;
                    endcase
                end else begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end

        vsync_d = (state_d == S_VSYNC);
        href_d  = (state_d == S_ACTIVE) && (bcnt_d < BW'(2*CAM_SCREEN_X));
        x_w     = bcnt_d >> 1;
`ifdef CAM_EMUL_BARS_EN
        case (32'(x_w) / ((CAM_SCREEN_X/8 > 0) ? CAM_SCREEN_X/8 : 1))
            0:       pix_w = 16'hFFFF;
            1:       pix_w = 16'hFFE0;
            2:       pix_w = 16'h07FF;
            3:       pix_w = 16'h07E0;
            4:       pix_w = 16'hF81F;
            5:       pix_w = 16'hF800;
            6:       pix_w = 16'h001F;
            default: pix_w = 16'h0000;
        endcase
`else
        pix_w = {8'(x_w), 8'(lcnt_d)};
`endif
        data_d = href_d ? (bcnt_d[0] ? pix_w[7:0] : pix_w[15:8]) : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            bcnt_q  <= '0;
            lcnt_q  <= '0;
            pclk_q  <= 1'b0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            pclk_q  <= ~pclk_q;
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            lcnt_q  <= lcnt_d;
            done_q  <= done_d;
            if (pclk_q) begin
                vsync_q <= vsync_d;
                href_q  <= href_d;
                data_q  <= data_d;
            end
        end
    end

    assign CAM_pclk    = pclk_q;
    assign CAM_vsync   = vsync_q;
    assign CAM_href    = href_q;
    assign CAM_px_data = data_q;
    assign frame_done  = done_q;
endmodule
